result_packer: RTL and testbench

- Downstream stage of the convolution engine. Consumes its result stream (result_valid/result_data, 20-bit signed accumulations).
- Requantizes each result to an 8-bit pixel: arithmetic shift, optional ReLU, saturation.
- Packs three pixels per 24-bit word and writes the words to the next layer's image BRAM through a small write FIFO that absorbs write-port backpressure.
- Flushes a partial word on conv_done, then pulses done.

---
 rtl/ren_pkg.sv | 17 +
 rtl/result_fifo.sv | 65 ++++++
 rtl/result_packer.sv | 206 ++++++++++++++++++++
 tb/tb_result_packer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ren_pkg.sv
// Shared constants and types for the result write-back path.
// Pixel geometry, saturation bounds and the packer FSM encoding.
package ren_pkg;
    localparam int PIX_WIDTH    = 8;
    localparam int PIX_PER_WORD = 3;

    localparam int UMAX = 255;
    localparam int SMIN = -128;
    localparam int SMAX = 127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } pk_state_e;
endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO with synchronous clear; head visible while !empty.
// Latency: a push is visible at the head the following cycle.
// Backpressure: push while full is honoured only when a pop happens the same cycle.
module result_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop   = pop && !empty;
    // When full, the slot written is the one being popped this cycle.
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_dat;
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/result_packer.sv
// Requantizes conv results to pixels, packs them into words and writes them out via a FIFO.
// Latency: third pixel's in_valid in cycle T gives wr_en in T+2 (FIFO empty, wr_ready=1).
// Backpressure: FIFO absorbs wr_ready stalls; a full word with no room is dropped (drop_err).
module result_packer #(
    parameter int RESULT_DWIDTH  = 20,
    parameter int SHFT_WIDTH     = 4,
    parameter int PIX_WIDTH      = ren_pkg::PIX_WIDTH,
    parameter int PIX_PER_WORD   = ren_pkg::PIX_PER_WORD,
    parameter int OUT_ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              conv_done,
    input  logic                              in_valid,
    input  logic signed [RESULT_DWIDTH-1:0]   in_data,
    input  logic                              relu_en,
    input  logic [SHFT_WIDTH-1:0]             shift,
    input  logic [OUT_ADDR_WIDTH-1:0]         base_addr,
    input  logic                              wr_ready,
    output logic                              wr_en,
    output logic [OUT_ADDR_WIDTH-1:0]         wr_addr,
    output logic [PIX_WIDTH*PIX_PER_WORD-1:0] wr_data,
    output logic                              done,
    output logic                              sat_flag,
    output logic                              drop_err
);
    import ren_pkg::*;

    localparam int WW = PIX_WIDTH * PIX_PER_WORD;
    localparam int LW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(PIX_PER_WORD - 1);
    localparam logic signed [RESULT_DWIDTH-1:0] UMAX_R = RESULT_DWIDTH'(UMAX);
    localparam logic signed [RESULT_DWIDTH-1:0] SMIN_R = RESULT_DWIDTH'(SMIN);
    localparam logic signed [RESULT_DWIDTH-1:0] SMAX_R = RESULT_DWIDTH'(SMAX);

    pk_state_e state_q, state_d;

    logic                      q_vld_q, q_vld_d;
    logic [PIX_WIDTH-1:0]      q_pix_q, q_pix_d;
    logic [LW-1:0]             lane_q, lane_d;
    logic [WW-1:0]             pack_q, pack_d;
    logic [OUT_ADDR_WIDTH-1:0] base_q, base_d;
    logic                      relu_q, relu_d;
    logic [SHFT_WIDTH-1:0]     shift_q, shift_d;
    logic [OUT_ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                      sat_q, sat_d;
    logic                      drop_q, drop_d;

    logic                            start_go;
    logic                            accept;
    logic signed [RESULT_DWIDTH-1:0] shv;
    logic [PIX_WIDTH-1:0]            pix;
    logic                            clip;
    logic [WW-1:0]                   push_word;
    logic                            fifo_push;
    logic [WW-1:0]                   fifo_push_dat;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic                            pop;

    assign start_go = (state_q == IDLE) && start;
    assign accept   = (state_q == RUN) && in_valid;
    assign pop      = !fifo_empty && wr_ready;

    // Quantize: ReLU zeroing is not counted as a clip.
    always_comb begin
        shv  = in_data >>> shift_q;
        pix  = shv[PIX_WIDTH-1:0];
        clip = 1'b0;
        if (relu_q) begin
            if (shv[RESULT_DWIDTH-1]) begin
                pix = '0;
            end else if (shv > UMAX_R) begin
                pix  = PIX_WIDTH'(UMAX);
                clip = 1'b1;
            end
        end else begin
            if (shv < SMIN_R) begin
                pix  = PIX_WIDTH'(SMIN);
                clip = 1'b1;
            end else if (shv > SMAX_R) begin
                pix  = PIX_WIDTH'(SMAX);
                clip = 1'b1;
            end
        end
    end

    always_comb begin
        push_word = pack_q;
        for (int l = 0; l < PIX_PER_WORD; l++) begin
            if (lane_q == LW'(l)) begin
                push_word[l*PIX_WIDTH +: PIX_WIDTH] = q_pix_q;
            end
        end
    end

    always_comb begin
        q_vld_d       = accept;
        q_pix_d       = accept ? pix : q_pix_q;
        lane_d        = lane_q;
        pack_d        = pack_q;
        base_d        = base_q;
        relu_d        = relu_q;
        shift_d       = shift_q;
        wcnt_d        = wcnt_q + {{(OUT_ADDR_WIDTH-1){1'b0}}, pop};
        sat_d         = sat_q | (accept & clip);
        fifo_push     = 1'b0;
        fifo_push_dat = pack_q;
        if (start_go) begin
            lane_d  = '0;
            pack_d  = '0;
            base_d  = base_addr;
            relu_d  = relu_en;
            shift_d = shift;
            wcnt_d  = '0;
            sat_d   = 1'b0;
        end else if (q_vld_q) begin
            if (lane_q == LAST_LANE) begin
                fifo_push     = 1'b1;
                fifo_push_dat = push_word;
                lane_d        = '0;
                pack_d        = '0;
            end else begin
                lane_d = lane_q + {{(LW-1){1'b0}}, 1'b1};
                pack_d = push_word;
            end
        end else if ((state_q == FLUSH) && (lane_q != '0) && (!fifo_full || pop)) begin
            // Partial word: unfilled lanes are already zero in pack_q.
            fifo_push = 1'b1;
            lane_d    = '0;
            pack_d    = '0;
        end
        drop_d = start_go ? 1'b0 : (drop_q | (fifo_push & fifo_full & ~pop));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN:   if (conv_done) state_d = FLUSH;
            FLUSH: if (!q_vld_q && (lane_q == '0) && fifo_empty) state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done = (state_q == FIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_vld_q <= 1'b0;
            q_pix_q <= '0;
            lane_q  <= '0;
            pack_q  <= '0;
            base_q  <= '0;
            relu_q  <= 1'b0;
            shift_q <= '0;
            wcnt_q  <= '0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            q_vld_q <= q_vld_d;
            q_pix_q <= q_pix_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            base_q  <= base_d;
            relu_q  <= relu_d;
            shift_q <= shift_d;
            wcnt_q  <= wcnt_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
        end
    end

    result_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clr      (start_go),
        .push     (fifo_push),
        .push_dat (fifo_push_dat),
        .pop      (pop),
        .head_dat (wr_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign wr_en    = pop;
    assign wr_addr  = base_q + wcnt_q;
    assign sat_flag = sat_q;
    assign drop_err = drop_q;
endmodule

// File: tb/tb_result_packer.sv
// Directed and randomized layers against a pixel/word reference model.
module tb_result_packer;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, conv_done, in_valid, relu_en, wr_ready;
    logic signed [19:0] in_data;
    logic [3:0]         shift;
    logic [7:0]         base_addr, wr_addr;
    logic [23:0]        wr_data;
    logic               wr_en, done, sat_flag, drop_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit rdy_rand = 1'b0;
    bit rdy_val = 1'b1;
    int t_third = 0;

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t got[$];
    int  res[$];
    int  exp_w[$];
    bit  exp_sat;

    result_packer dut (
        .clk(clk), .reset(rst_n), .start(start), .conv_done(conv_done),
        .in_valid(in_valid), .in_data(in_data), .relu_en(relu_en), .shift(shift),
        .base_addr(base_addr), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .done(done), .sat_flag(sat_flag), .drop_err(drop_err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    initial forever begin
        @(negedge clk);
        if (wr_en === 1'b1) got.push_back('{int'(wr_addr), int'(wr_data), cyc});
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Reference pixel: shift, then clamp to the selected range.
    function automatic int quant(input int r, input bit relu, input int sh, output bit clipped);
        int v;
        v = r >>> sh;
        clipped = 1'b0;
        if (relu) begin
            if (v < 0) return 0;
            if (v > 255) begin clipped = 1'b1; return 255; end
            return v;
        end
        if (v < -128) begin clipped = 1'b1; return 128; end
        if (v > 127) begin clipped = 1'b1; return 127; end
        return v & 255;
    endfunction

    task automatic build_expect(input bit relu, input int sh);
        int w;
        bit c;
        exp_w.delete();
        exp_sat = 1'b0;
        w = 0;
        for (int i = 0; i < res.size(); i++) begin
            w |= quant(res[i], relu, sh, c) << (8 * (i % 3));
            exp_sat |= c;
            if (i % 3 == 2) begin exp_w.push_back(w); w = 0; end
        end
        if (res.size() % 3 != 0) exp_w.push_back(w);
    endtask

    task automatic run_layer(input int base, input bit relu, input int sh, input bit gaps,
                             input bit cd_last, input int hold, input bit exp_drop, input bit junk);
        int d0;
        int n;
        build_expect(relu, sh);
        if (exp_drop) while (exp_w.size() > 4) void'(exp_w.pop_back());
        got.delete();
        d0 = done_cnt;
        if (junk) begin in_valid = 1'b1; in_data = 20'h7FFFF; tick(); in_valid = 1'b0; end
        base_addr = 8'(base); relu_en = relu; shift = 4'(sh); start = 1'b1;
        tick();
        start = 1'b0;
        relu_en = ~relu; shift = 4'($urandom); base_addr = 8'($urandom);
        for (int i = 0; i < res.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_data = 20'(res[i]);
            conv_done = cd_last && (i == res.size() - 1);
            if (junk && i == 1) start = 1'b1;
            if (i == 2) t_third = cyc;
            tick();
            in_valid = 1'b0; conv_done = 1'b0; start = 1'b0;
        end
        if (!cd_last) begin conv_done = 1'b1; tick(); conv_done = 1'b0; end
        if (junk) begin in_valid = 1'b1; in_data = 20'h07FFF; tick(); in_valid = 1'b0; end
        if (hold > 0) begin repeat (hold) tick(); rdy_val = 1'b1; end
        for (int k = 0; k < 400 && done_cnt == d0; k++) tick();
        chk("done_seen", 32'(done_cnt != d0), 1);
        repeat (3) tick();
        chk("done_pulses", done_cnt - d0, 1);
        chk("num_writes", got.size(), exp_w.size());
        n = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
        for (int k = 0; k < n; k++) begin
            chk("wr_addr", got[k].addr, (base + k) & 255);
            chk("wr_data", got[k].data, exp_w[k]);
        end
        chk("sat_flag", 32'(sat_flag), 32'(exp_sat));
        chk("drop_err", 32'(drop_err), 32'(exp_drop));
    endtask

    initial begin
        rst_n = 1'b0; start = 0; conv_done = 0; in_valid = 0; in_data = '0;
        relu_en = 0; shift = '0; base_addr = '0;
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sat", 32'(sat_flag), 0);
        chk("rst_drop", 32'(drop_err), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        rst_n = 1'b1;
        tick();

        // 1: ReLU, shift 2
        res = '{40, -8, 1200};
        rdy_val = 1'b1;
        run_layer(8'h10, 1'b1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("t1_word", (got.size() > 0) ? got[0].data : -1, 32'hFF000A);
        chk("t1_addr", (got.size() > 0) ? got[0].addr : -1, 32'h10);
        chk("t1_latency", (got.size() > 0) ? got[0].cyc - t_third : -1, 2);

        // 2: signed, conv_done on the last valid, partial flush
        res = '{-300, 5, 127, 200};
        run_layer(8'h40, 1'b0, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("t2_word0", (got.size() > 0) ? got[0].data : -1, 32'h7F0580);
        chk("t2_word1", (got.size() > 1) ? got[1].data : -1, 32'h00007F);

        // 3: FIFO fills exactly, then drains back to back
        res.delete();
        for (int i = 0; i < 12; i++) res.push_back(i * 7 - 20);
        rdy_val = 1'b0;
        run_layer(8'h20, 1'b0, 0, 1'b0, 1'b0, 20, 1'b0, 1'b0);
        for (int k = 1; k < got.size(); k++) chk("t3_consec", got[k].cyc - got[0].cyc, k);

        // 4: fifth word dropped
        res.delete();
        for (int i = 0; i < 15; i++) res.push_back(i * 3);
        rdy_val = 1'b0;
        run_layer(8'h30, 1'b1, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0);

        // 5: address wrap
        res.delete();
        for (int i = 0; i < 9; i++) res.push_back(i + 1);
        run_layer(8'hFE, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("t5_wrap", (got.size() > 2) ? got[2].addr : -1, 0);

        // 6: reset mid-run with the FIFO holding words
        rdy_val = 1'b0;
        base_addr = 8'h50; relu_en = 1'b0; shift = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_data = 20'(5000 + i); tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t6_sat_before", 32'(sat_flag), 1);
        chk("t6_drop_before", 32'(drop_err), 1);
        rdy_val = 1'b1;
        tick();
        rst_n = 1'b0;
        got.delete();
        #1;
        chk("t6_wr_en_now", 32'(wr_en), 0);
        repeat (3) tick();
        chk("t6_no_writes", got.size(), 0);
        chk("t6_sat", 32'(sat_flag), 0);
        chk("t6_drop", 32'(drop_err), 0);
        chk("t6_wr_addr", 32'(wr_addr), 0);
        rst_n = 1'b1;
        tick();
        res = '{1, 2, 3, 4, 5};
        run_layer(8'h60, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Randomized layers, at most four full words so nothing can drop
        rdy_rand = 1'b1;
        for (int it = 0; it < 12; it++) begin
            logic [19:0] t;
            int n;
            n = $urandom_range(1, 12);
            res.delete();
            for (int i = 0; i < n; i++) begin
                t = 20'($urandom);
                res.push_back(int'($signed(t)));
            end
            run_layer($urandom_range(0, 255), 1'($urandom), $urandom_range(0, 15),
                      1'($urandom), 1'($urandom), 0, 1'b0, 1'b1);
        end
        rdy_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
